// File: rtl/sprite_layer_mixer.sv
// sprite_layer_mixer: three-stage sprite compositor over a video timing stream.
// Stage 1 does the per-layer box test and ROM addressing, stage 2 waits on the
// synchronous sprite ROMs, and stage 3 picks the topmost opaque layer.
// Layer positions and enables are latched at frame start so a frame never tears.
// Optional feature: define LAYER_COLLISION_EN to build per-frame collision flags
// between layer 0 and every other layer.

// Per-layer stage 1: box test against the frame's latched position plus ROM address.
module sprite_layer_lane #(
   parameter int SPR_W  = 64,
   parameter int SPR_H  = 64,
   parameter int ADDR_W = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   input  logic [10:0]       hcount,
   input  logic [10:0]       vcount,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              inbox
);
   logic [10:0] x_lo, y_lo, x_hi, y_hi, dx, dy;
   logic        hit;

   // 11-bit bounds: a 10-bit corner plus sprite size cannot wrap.
   assign x_lo = {1'b0, x};
   assign y_lo = {1'b0, y};
   assign x_hi = x_lo + 11'(SPR_W);
   assign y_hi = y_lo + 11'(SPR_H);
   assign hit  = en && (hcount >= x_lo) && (hcount < x_hi) &&
                 (vcount >= y_lo) && (vcount < y_hi);
   assign dx   = hcount - x_lo;
   assign dy   = vcount - y_lo;

   // Register the in-box flag and the row-major sprite address (0 when outside).
   always_ff @(posedge clk) begin
      if (!rst) begin
         rom_addr <= '0;
         inbox    <= 1'b0;
      end else begin
         inbox    <= hit;
         rom_addr <= hit ? (ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx)) : '0;
      end
   end
endmodule

module sprite_layer_mixer #(
   parameter int          NUM_LAYERS = 3,
   parameter int          SPR_W      = 64,
   parameter int          SPR_H      = 64,
   parameter int          ADDR_W     = 20,
   parameter logic [11:0] KEY_COLOR  = 12'h000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [10:0]                  vcount_in,
   input  logic [10:0]                  hcount_in,
   input  logic                         vsync_in,
   input  logic                         hsync_in,
   input  logic                         vblnk_in,
   input  logic                         hblnk_in,
   input  logic [11:0]                  rgb_in,
   input  logic [NUM_LAYERS-1:0]        layer_en,
   input  logic [NUM_LAYERS*10-1:0]     layer_x,
   input  logic [NUM_LAYERS*10-1:0]     layer_y,
   output logic [NUM_LAYERS*ADDR_W-1:0] rom_addr,
   input  logic [NUM_LAYERS*12-1:0]     rom_data,
   output logic [10:0]                  vcount_out,
   output logic [10:0]                  hcount_out,
   output logic                         vsync_out,
   output logic                         hsync_out,
   output logic                         vblnk_out,
   output logic                         hblnk_out,
   output logic [11:0]                  rgb_out,
   output logic [NUM_LAYERS-1:0]        collide,
   output logic                         collide_valid
);
   typedef struct packed {
      logic [10:0] vcount;
      logic [10:0] hcount;
      logic        vsync;
      logic        hsync;
      logic        vblnk;
      logic        hblnk;
      logic [11:0] rgb;
   } stream_t;

   stream_t                     s_in, s1, s2, s3;
   logic                        frame_start;
   logic [NUM_LAYERS-1:0]       shadow_en, eff_en;
   logic [NUM_LAYERS*10-1:0]    shadow_x, shadow_y, eff_x, eff_y;
   logic [NUM_LAYERS-1:0]       inbox1, inbox2, opaque;
   logic [11:0]                 pix;

   assign s_in        = '{vcount: vcount_in, hcount: hcount_in, vsync: vsync_in,
                          hsync: hsync_in, vblnk: vblnk_in, hblnk: hblnk_in,
                          rgb: rgb_in};
   assign frame_start = (vcount_in == 11'd0) && (hcount_in == 11'd0);

   // The frame-start pixel itself already belongs to the new frame, so it
   // sees the live configuration; every later pixel sees the latched copy.
   assign eff_en = frame_start ? layer_en : shadow_en;
   assign eff_x  = frame_start ? layer_x  : shadow_x;
   assign eff_y  = frame_start ? layer_y  : shadow_y;

   // Latch layer configuration once per frame; cleared by reset so layers
   // stay dark until the first frame start after release.
   always_ff @(posedge clk) begin
      if (!rst) begin
         shadow_en <= '0;
         shadow_x  <= '0;
         shadow_y  <= '0;
      end else if (frame_start) begin
         shadow_en <= layer_en;
         shadow_x  <= layer_x;
         shadow_y  <= layer_y;
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_LAYERS; g++) begin : g_lane
         sprite_layer_lane #(.SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (eff_en[g]),
            .x        (eff_x[g*10 +: 10]),
            .y        (eff_y[g*10 +: 10]),
            .hcount   (hcount_in),
            .vcount   (vcount_in),
            .rom_addr (rom_addr[g*ADDR_W +: ADDR_W]),
            .inbox    (inbox1[g])
         );
         assign opaque[g] = inbox2[g] && (rom_data[g*12 +: 12] != KEY_COLOR);
      end
   endgenerate

   // Stream delay for stages 1 and 2, in-box flags travel with the ROM latency.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1     <= '0;
         s2     <= '0;
         inbox2 <= '0;
      end else begin
         s1     <= s_in;
         s2     <= s1;
         inbox2 <= inbox1;
      end
   end

   // Highest-index opaque layer wins; blanking forces black.
   always_comb begin
      pix = s2.rgb;
      for (int i = 0; i < NUM_LAYERS; i++)
         if (opaque[i]) pix = rom_data[i*12 +: 12];
      if (s2.hblnk || s2.vblnk) pix = 12'h000;
   end

   // Stage 3 output register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s3 <= '0;
      end else begin
         s3     <= s2;
         s3.rgb <= pix;
      end
   end

   assign vcount_out = s3.vcount;
   assign hcount_out = s3.hcount;
   assign vsync_out  = s3.vsync;
   assign hsync_out  = s3.hsync;
   assign vblnk_out  = s3.vblnk;
   assign hblnk_out  = s3.hblnk;
   assign rgb_out    = s3.rgb;

`ifdef LAYER_COLLISION_EN
   logic [NUM_LAYERS-1:0] acc, hit;

   // Layer 0 against each other layer at the same stage-3 pixel; bit 0 never set.
   always_comb begin
      hit = '0;
      for (int i = 1; i < NUM_LAYERS; i++)
         hit[i] = opaque[0] && opaque[i];
   end

   // Publish the previous frame's hits at frame start; a hit on that cycle
   // seeds the new frame's accumulator.
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc           <= '0;
         collide       <= '0;
         collide_valid <= 1'b0;
      end else if (frame_start) begin
         collide       <= acc;
         collide_valid <= 1'b1;
         acc           <= hit;
      end else begin
         collide_valid <= 1'b0;
         acc           <= acc | hit;
      end
   end
`else
   assign collide       = '0;
   assign collide_valid = 1'b0;
`endif
endmodule
